// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_TST = 1'b1;

    localparam int RD_LAT_MAX = 4;
    localparam int STARVE_W   = 4;
    // Latency counter must hold values up to RD_LAT_MAX
    localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority winner select with a starvation counter that lets the
// test loader through after STARVE_MAX consecutive contested CPU grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic tst_req,
    input  logic grant,
    output logic winner
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_r;
    logic                winner_s;

    // Winner select: CPU first unless the test loader has waited long enough
    always_comb begin
        winner_s = OWN_CPU;
        if (tst_req && (!cpu_req || (starve_cnt_r == STARVE_LIM))) begin
            winner_s = OWN_TST;
        end else begin
            winner_s = OWN_CPU;
        end
    end

    assign winner = winner_s;

    // Starvation counter, updated only on an actual grant
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (grant) begin
            if (winner_s == OWN_TST) begin
                starve_cnt_r <= '0;
            end else if (tst_req) begin
                if (starve_cnt_r < STARVE_LIM) begin
                    starve_cnt_r <= starve_cnt_r + STARVE_W'(1'b1);
                end
            end else begin
                starve_cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the test loader.
// Optional grant counters are enabled with `define MEM_ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          tst_req,
    input  logic          tst_we,
    input  logic [AW-1:0] tst_addr,
    input  logic [DW-1:0] tst_wdata,
    output logic          tst_ack,
    output logic [DW-1:0] tst_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   cpu_grants,
    output logic [15:0]   tst_grants
`endif
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    arb_state_e        state_r, next_state_s;
    logic              own_r, we_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     wdata_r;
    logic [LAT_W-1:0]  lat_cnt_r;

    logic              winner_s, grant_s, capture_s, mem_active_s;
    logic              nxt_own_s, nxt_we_s;
    logic [AW-1:0]     nxt_addr_s;
    logic [DW-1:0]     nxt_wdata_s;

    logic [AW-1:0]     mem_addr_r;
    logic [DW-1:0]     mem_wdata_r, cpu_rdata_r, tst_rdata_r;
    logic              mem_rd_r, mem_wr_r, cpu_ack_r, tst_ack_r, busy_r;

    assign grant_s = (state_r == IDLE) && (cpu_req || tst_req);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .tst_req (tst_req),
        .grant   (grant_s),
        .winner  (winner_s)
    );

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) next_state_s = ACCESS;
                else         next_state_s = IDLE;
            end
            ACCESS: begin
                if (we_r || (RD_LAT == 32'sd1)) next_state_s = ACK;
                else                            next_state_s = WAIT;
            end
            WAIT: begin
                if (lat_cnt_r == LAT_LAST) next_state_s = ACK;
                else                       next_state_s = WAIT;
            end
            ACK:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Request fields as they will be after this edge
    always_comb begin
        nxt_own_s   = own_r;
        nxt_we_s    = we_r;
        nxt_addr_s  = addr_r;
        nxt_wdata_s = wdata_r;
        if (grant_s) begin
            nxt_own_s = winner_s;
            if (winner_s == OWN_TST) begin
                nxt_we_s    = tst_we;
                nxt_addr_s  = tst_addr;
                nxt_wdata_s = tst_wdata;
            end else begin
                nxt_we_s    = cpu_we;
                nxt_addr_s  = cpu_addr;
                nxt_wdata_s = cpu_wdata;
            end
        end else begin
            nxt_own_s = own_r;
        end
    end

    // Read data is sampled at the end of the last mem_rd cycle
    always_comb begin
        capture_s = 1'b0;
        if (state_r == ACCESS) begin
            capture_s = !we_r && (RD_LAT == 32'sd1);
        end else if (state_r == WAIT) begin
            capture_s = (lat_cnt_r == LAT_LAST);
        end else begin
            capture_s = 1'b0;
        end
    end

    assign mem_active_s = (next_state_s == ACCESS) || (next_state_s == WAIT);

    // FSM state, latched request and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            own_r     <= OWN_CPU;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            lat_cnt_r <= '0;
        end else begin
            state_r   <= next_state_s;
            own_r     <= nxt_own_s;
            we_r      <= nxt_we_s;
            addr_r    <= nxt_addr_s;
            wdata_r   <= nxt_wdata_s;
            if ((state_r == ACCESS) || (state_r == WAIT)) begin
                lat_cnt_r <= lat_cnt_r + LAT_W'(1'b1);
            end else begin
                lat_cnt_r <= '0;
            end
        end
    end

    // Registered memory strobes, acks and status, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            cpu_ack_r   <= 1'b0;
            tst_ack_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_addr_r  <= mem_active_s ? nxt_addr_s : '0;
            mem_wdata_r <= ((next_state_s == ACCESS) && nxt_we_s) ? nxt_wdata_s : '0;
            mem_rd_r    <= mem_active_s && !nxt_we_s;
            mem_wr_r    <= (next_state_s == ACCESS) && nxt_we_s;
            cpu_ack_r   <= (next_state_s == ACK) && (nxt_own_s == OWN_CPU);
            tst_ack_r   <= (next_state_s == ACK) && (nxt_own_s == OWN_TST);
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Per-requester read data holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_r <= '0;
            tst_rdata_r <= '0;
        end else if (capture_s) begin
            if (own_r == OWN_TST) tst_rdata_r <= mem_rdata;
            else                  cpu_rdata_r <= mem_rdata;
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;
    assign cpu_ack   = cpu_ack_r;
    assign tst_ack   = tst_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign tst_rdata = tst_rdata_r;
    assign busy      = busy_r;
    assign owner     = own_r;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_grants_r, tst_grants_r;

    // Saturating grant counters, bumped on each ack pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_grants_r <= 16'h0000;
            tst_grants_r <= 16'h0000;
        end else begin
            if (cpu_ack_r && (cpu_grants_r != 16'hFFFF)) cpu_grants_r <= cpu_grants_r + 16'h0001;
            if (tst_ack_r && (tst_grants_r != 16'hFFFF)) tst_grants_r <= tst_grants_r + 16'h0001;
        end
    end

    assign cpu_grants = cpu_grants_r;
    assign tst_grants = tst_grants_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 (a_*)
// and one with RD_LAT=3 (b_*), sharing the requester inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, tst_req, tst_we;
    logic [15:0] cpu_addr, tst_addr;
    logic [7:0]  cpu_wdata, tst_wdata;

    logic        a_cpu_ack, a_tst_ack, a_mem_rd, a_mem_wr, a_busy, a_owner;
    logic [7:0]  a_cpu_rdata, a_tst_rdata, a_mem_wdata, a_mem_rdata;
    logic [15:0] a_mem_addr;
    logic        b_cpu_ack, b_tst_ack, b_mem_rd, b_mem_wr, b_busy, b_owner;
    logic [7:0]  b_cpu_rdata, b_tst_rdata, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_mem_addr;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] a_cpu_grants, a_tst_grants, b_cpu_grants, b_tst_grants;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // Memory contents as a fixed function of address: 0x0010 holds 0x3C
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h2C;
    endfunction

    assign a_mem_rdata = mem_model(a_mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_port_arbiter #(.AW(16), .DW(8), .RD_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .tst_req(tst_req), .tst_we(tst_we), .tst_addr(tst_addr), .tst_wdata(tst_wdata),
        .tst_ack(a_tst_ack), .tst_rdata(a_tst_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
        .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
`ifdef MEM_ARB_STATS_EN
        , .cpu_grants(a_cpu_grants), .tst_grants(a_tst_grants)
`endif
    );

    mem_port_arbiter #(.AW(16), .DW(8), .RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .tst_req(tst_req), .tst_we(tst_we), .tst_addr(tst_addr), .tst_wdata(tst_wdata),
        .tst_ack(b_tst_ack), .tst_rdata(b_tst_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
`ifdef MEM_ARB_STATS_EN
        , .cpu_grants(b_cpu_grants), .tst_grants(b_tst_grants)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic access_a(input logic is_tst, input logic we, input logic [15:0] addr);
        logic seen;
        seen = 1'b0;
        if (is_tst) begin tst_req = 1'b1; tst_we = we; tst_addr = addr; end
        else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; end
        for (int c = 0; c < 10 && !seen; c++) begin
            step(1);
            if (a_cpu_ack || a_tst_ack) seen = 1'b1;
        end
        check("stats_ack_seen", seen, 1'b1);
        cpu_req = 1'b0;
        tst_req = 1'b0;
        step(5);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic [15:0] last_addr;
        logic [15:0] exp_addr;

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        tst_req = 1'b0; tst_we = 1'b0; tst_addr = 16'h0000; tst_wdata = 8'h00;
        step(2);

        // Reset state
        check("rst_busy",   a_busy,   1'b0);
        check("rst_mem_wr", a_mem_wr, 1'b0);
        check("rst_mem_rd", b_mem_rd, 1'b0);
        check("rst_addr",   b_mem_addr, 16'h0000);
        check("rst_ack",    {a_cpu_ack, a_tst_ack, b_cpu_ack, b_tst_ack}, 4'h0);
        check("rst_rdata",  {b_cpu_rdata, b_tst_rdata}, 16'h0000);
        rst = 1'b0;
        step(1);

        // CPU write 0x2000 <= 0xA5
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hA5;
        step(1);
        check("wr_c1_mem_wr", a_mem_wr,    1'b1);
        check("wr_c1_mem_rd", a_mem_rd,    1'b0);
        check("wr_c1_addr",   a_mem_addr,  16'h2000);
        check("wr_c1_wdata",  a_mem_wdata, 8'hA5);
        check("wr_c1_busy",   a_busy,      1'b1);
        check("wr_c1_ack",    a_cpu_ack,   1'b0);
        step(1);
        check("wr_c2_cpu_ack", a_cpu_ack,  1'b1);
        check("wr_c2_tst_ack", a_tst_ack,  1'b0);
        check("wr_c2_mem_wr",  a_mem_wr,   1'b0);
        check("wr_c2_addr",    a_mem_addr, 16'h0000);
        check("wr_c2_rdata",   a_cpu_rdata, 8'h00);
        cpu_req = 1'b0;
        step(1);
        check("wr_c3_ack",  a_cpu_ack, 1'b0);
        check("wr_c3_busy", a_busy,    1'b0);

        // CPU read 0x1234 (memory 0x0A): one cycle on a, three on b
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        step(1);
        check("rd1_c1_mem_rd", a_mem_rd, 1'b1);
        check("rd1_c1_mem_wr", a_mem_wr, 1'b0);
        step(1);
        check("rd1_c2_ack",    a_cpu_ack,   1'b1);
        check("rd1_c2_rdata",  a_cpu_rdata, 8'h0A);
        check("rd1_c2_mem_rd", a_mem_rd,    1'b0);
        check("rd3_c2_mem_rd", b_mem_rd,    1'b1);
        check("rd3_c2_ack",    b_cpu_ack,   1'b0);
        cpu_req = 1'b0;
        step(2);
        check("rd3_c4_ack",   b_cpu_ack,   1'b1);
        check("rd3_c4_rdata", b_cpu_rdata, 8'h0A);
        step(1);

        // Test read of 0x0010 with RD_LAT=3
        tst_req = 1'b1; tst_we = 1'b0; tst_addr = 16'h0010;
        for (int c = 1; c <= 3; c++) begin
            step(1);
            check("trd_mem_rd", b_mem_rd,  1'b1);
            check("trd_no_ack", b_tst_ack, 1'b0);
        end
        check("trd_owner", b_owner,    1'b1);
        check("trd_addr",  b_mem_addr, 16'h0010);
        step(1);
        check("trd_c4_ack",       b_tst_ack,   1'b1);
        check("trd_c4_rdata",     b_tst_rdata, 8'h3C);
        check("trd_c4_cpu_rdata", b_cpu_rdata, 8'h0A);
        check("trd_c4_cpu_ack",   b_cpu_ack,   1'b0);
        check("trd_c4_mem_rd",    b_mem_rd,    1'b0);
        tst_req = 1'b0;
        step(1);
        check("trd_c5_ack", b_tst_ack, 1'b0);
        step(4);

        // Both requesting writes continuously: C C C C T C
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h11;
        tst_req = 1'b1; tst_we = 1'b1; tst_addr = 16'hFFFF; tst_wdata = 8'h22;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            last_addr = 16'h0000;
            for (int c = 0; c < 8 && !found; c++) begin
                step(1);
                if (a_mem_wr) last_addr = a_mem_addr;
                if (a_cpu_ack || a_tst_ack) found = 1'b1;
            end
            exp_addr = (k == 4) ? 16'hFFFF : 16'h0100;
            check("arb_ack_seen", found,     1'b1);
            check("arb_tst_win",  a_tst_ack, (k == 4) ? 1'b1 : 1'b0);
            check("arb_cpu_win",  a_cpu_ack, (k == 4) ? 1'b0 : 1'b1);
            check("arb_addr",     last_addr, exp_addr);
        end
        cpu_req = 1'b0;
        tst_req = 1'b0;
        step(3);

        // Back-to-back CPU writes: new ACCESS two cycles after ack
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00AB; cpu_wdata = 8'h5A;
        step(2);
        check("b2b_ack", a_cpu_ack, 1'b1);
        cpu_req = 1'b0;
        step(1);
        check("b2b_idle_wr", a_mem_wr, 1'b0);
        cpu_req = 1'b1;
        step(1);
        check("b2b_access_wr", a_mem_wr,    1'b1);
        check("b2b_wdata",     a_mem_wdata, 8'h5A);
        step(1);
        check("b2b_ack2", a_cpu_ack, 1'b1);
        cpu_req = 1'b0;
        step(3);

        // Reset during the WAIT cycle of a RD_LAT=3 read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4321;
        step(2);
        check("rstw_in_wait", b_mem_rd,    1'b1);
        check("rstw_prev",    b_tst_rdata, 8'h3C);
        rst = 1'b1;
        step(1);
        check("rstw_busy",  b_busy,     1'b0);
        check("rstw_rd",    b_mem_rd,   1'b0);
        check("rstw_ack",   b_cpu_ack,  1'b0);
        check("rstw_addr",  b_mem_addr, 16'h0000);
        check("rstw_rdata", {b_cpu_rdata, b_tst_rdata}, 16'h0000);
        rst = 1'b0;
        cpu_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("rstw_no_ack", b_cpu_ack | b_tst_ack, 1'b0);
        end

`ifdef MEM_ARB_STATS_EN
        // Grant counters: 3 CPU writes, 2 test reads
        check("stats_start", {a_cpu_grants, a_tst_grants}, 32'h0000_0000);
        cpu_wdata = 8'h77;
        access_a(1'b0, 1'b1, 16'h3000);
        access_a(1'b1, 1'b0, 16'h0010);
        access_a(1'b0, 1'b1, 16'h3001);
        access_a(1'b1, 1'b0, 16'h0011);
        access_a(1'b0, 1'b1, 16'h3002);
        check("stats_cpu", a_cpu_grants, 16'd3);
        check("stats_tst", a_tst_grants, 16'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("stats_rst_cpu", a_cpu_grants, 16'd0);
        check("stats_rst_tst", a_tst_grants, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
